// File: rtl/maze_path_recorder_if.sv
// Interface bundling the solver move stream, the replay stream and the status
// signals of maze_path_recorder.
//   master : solver/consumer side (drives start, moves, done/fail, rd_ready)
//   slave  : recorder side (drives replay coordinates and status)
interface maze_path_recorder_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned AW      = 8
);
  logic               start;
  logic               move_valid;
  logic [1:0]         move;
  logic               done;
  logic               fail;
  logic               rd_valid;
  logic               rd_ready;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               busy;
  logic [AW:0]        path_len;
  logic               ok;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    output start, move_valid, move, done, fail, rd_ready,
    input  rd_valid, rd_x, rd_y, busy, path_len, ok, err, err_code
  );

  modport slave (
    input  start, move_valid, move, done, fail, rd_ready,
    output rd_valid, rd_x, rd_y, busy, path_len, ok, err, err_code
  );
endinterface

// File: rtl/maze_path_recorder.sv
// maze_path_recorder: records the rat_in_maze solver's move stream, tracks the
// rat position, validates the path (in bounds, within buffer depth, ends at the
// goal corner) and replays the positions as a ready/valid stream.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave modport of maze_path_recorder_if
//              in : start, move_valid, move, done, fail, rd_ready
//              out: rd_valid, rd_x, rd_y (combinational), busy, path_len, ok,
//                   err, err_code (registered)
module maze_path_recorder #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8
) (
  input logic                 clk,
  input logic                 rst,
  maze_path_recorder_if.slave bus
);

  localparam logic [COORD_W-1:0] GOAL = {COORD_W{1'b1}};
  localparam logic [AW:0]        FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, REPLAY, FINISH} state_t;

  state_t             state;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic [COORD_W-1:0] rp_x, rp_y;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        path_len;
  logic               bnd_flag, ovf_flag, fail_flag;
  logic               rd_valid, busy, ok, err;
  logic [1:0]         err_code;
  logic [1:0]         mem [DEPTH];

  logic [COORD_W:0]   cap_sx, cap_sy;
  logic [1:0]         rd_mv;
  logic [COORD_W-1:0] rd_x_c, rd_y_c;
  logic               cap_we;

  // One-axis step with a spare MSB: the MSB flags a step past 0 or the max.
  function automatic logic [COORD_W:0] move_axis(input logic [COORD_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
    logic [COORD_W:0] r;
    r = {1'b0, c};
    if (inc)      r = r + (COORD_W+1)'(1);
    else if (dec) r = r - (COORD_W+1)'(1);
    return r;
  endfunction

  // Capture step and replay coordinate (replay paths are already in bounds).
  always_comb begin
    cap_sx = move_axis(pos_x, bus.move == 2'b01, bus.move == 2'b10);
    cap_sy = move_axis(pos_y, bus.move == 2'b11, bus.move == 2'b00);
    rd_mv  = mem[rd_ptr];
    rd_x_c = '0;
    rd_y_c = '0;
    if (rd_valid) begin
      rd_x_c = COORD_W'(move_axis(rp_x, rd_mv == 2'b01, rd_mv == 2'b10));
      rd_y_c = COORD_W'(move_axis(rp_y, rd_mv == 2'b11, rd_mv == 2'b00));
    end
    cap_we = (state == CAPTURE) && !bus.start && bus.move_valid && (path_len != FULL);
  end

  // Move buffer.
  always_ff @(posedge clk) begin
    if (cap_we) mem[wr_ptr] <= bus.move;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos_x     <= '0;
      pos_y     <= '0;
      rp_x      <= '0;
      rp_y      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      path_len  <= '0;
      bnd_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
      fail_flag <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      ok        <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else if (bus.start) begin
      state     <= CAPTURE;
      pos_x     <= '0;
      pos_y     <= '0;
      rp_x      <= '0;
      rp_y      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      path_len  <= '0;
      bnd_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
      fail_flag <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b1;
      ok        <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      case (state)
        CAPTURE: begin
          if (bus.move_valid) begin
            if (path_len == FULL) begin
              ovf_flag <= 1'b1;
            end else begin
              wr_ptr   <= wr_ptr + AW'(1);
              path_len <= path_len + (AW+1)'(1);
              // Saturate: an out-of-range step leaves the coordinate unchanged.
              pos_x    <= cap_sx[COORD_W] ? pos_x : cap_sx[COORD_W-1:0];
              pos_y    <= cap_sy[COORD_W] ? pos_y : cap_sy[COORD_W-1:0];
              if (cap_sx[COORD_W] || cap_sy[COORD_W]) bnd_flag <= 1'b1;
            end
          end
          if (bus.done) begin
            fail_flag <= bus.fail;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (fail_flag || ovf_flag || bnd_flag || pos_x != GOAL || pos_y != GOAL) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
            if (fail_flag)     err_code <= 2'b01;
            else if (ovf_flag) err_code <= 2'b11;
            else if (bnd_flag) err_code <= 2'b10;
            else               err_code <= 2'b00;
          end else begin
            rp_x     <= '0;
            rp_y     <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b1;
            state    <= REPLAY;
          end
        end
        REPLAY: begin
          if (rd_valid && bus.rd_ready) begin
            rp_x   <= rd_x_c;
            rp_y   <= rd_y_c;
            rd_ptr <= rd_ptr + AW'(1);
            if ({1'b0, rd_ptr} == path_len - (AW+1)'(1)) begin
              rd_valid <= 1'b0;
              ok       <= 1'b1;
              busy     <= 1'b0;
              state    <= FINISH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_valid = rd_valid;
  assign bus.rd_x     = rd_x_c;
  assign bus.rd_y     = rd_y_c;
  assign bus.busy     = busy;
  assign bus.path_len = path_len;
  assign bus.ok       = ok;
  assign bus.err      = err;
  assign bus.err_code = err_code;

endmodule

// File: tb/tb_maze_path_recorder.sv
// Testbench for maze_path_recorder: random and directed solves checked against
// a position/flag model computed from the move list.
module tb_maze_path_recorder;
  localparam int unsigned CW    = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int          MAXC  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_path_recorder_if #(.COORD_W(CW), .AW(AW)) bus ();

  maze_path_recorder #(.COORD_W(CW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] mv_q[$];
  bit         fail_b;
  int         exp_len;
  bit         exp_err;
  logic [1:0] exp_code;
  int         exp_x[$];
  int         exp_y[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the move list with plain integers.
  task automatic build_model();
    int x = 0;
    int y = 0;
    bit bnd = 0;
    bit ovf = 0;
    exp_x.delete();
    exp_y.delete();
    exp_len = 0;
    foreach (mv_q[i]) begin
      if (exp_len == int'(DEPTH)) begin
        ovf = 1;
      end else begin
        case (mv_q[i])
          2'd0: y = y - 1;
          2'd1: x = x + 1;
          2'd2: x = x - 1;
          default: y = y + 1;
        endcase
        if (x < 0)    begin x = 0;    bnd = 1; end
        if (x > MAXC) begin x = MAXC; bnd = 1; end
        if (y < 0)    begin y = 0;    bnd = 1; end
        if (y > MAXC) begin y = MAXC; bnd = 1; end
        exp_len++;
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
    end
    exp_err  = 1;
    exp_code = 2'b00;
    if (fail_b)                        exp_code = 2'b01;
    else if (ovf)                      exp_code = 2'b11;
    else if (bnd)                      exp_code = 2'b10;
    else if (!(x == MAXC && y == MAXC)) exp_code = 2'b00;
    else                               exp_err  = 0;
  endtask

  // Random in-bounds detour walk, then a random monotone run to the goal.
  task automatic gen_goal_path(input int detours);
    int x = 0;
    int y = 0;
    int nx, ny;
    logic [1:0] m;
    mv_q.delete();
    repeat (detours) begin
      do begin
        m  = 2'($urandom_range(0, 3));
        nx = x + ((m == 2'd1) ? 1 : 0) - ((m == 2'd2) ? 1 : 0);
        ny = y + ((m == 2'd3) ? 1 : 0) - ((m == 2'd0) ? 1 : 0);
      end while (nx < 0 || nx > MAXC || ny < 0 || ny > MAXC);
      x = nx;
      y = ny;
      mv_q.push_back(m);
    end
    while (x < MAXC || y < MAXC) begin
      if (x < MAXC && (y == MAXC || $urandom_range(0, 1) == 1)) begin
        mv_q.push_back(2'd1);
        x++;
      end else begin
        mv_q.push_back(2'd3);
        y++;
      end
    end
  endtask

  // Start pulse, moves with random idle gaps, then done (optionally with the last move).
  task automatic drive_capture(input bit done_with_last, input int gap_max);
    bit dwl;
    dwl = done_with_last && (mv_q.size() > 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    foreach (mv_q[i]) begin
      repeat ($urandom_range(0, gap_max)) tick();
      bus.move_valid = 1'b1;
      bus.move       = mv_q[i];
      if (dwl && i == mv_q.size() - 1) begin
        bus.done = 1'b1;
        bus.fail = fail_b;
      end
      tick();
      bus.move_valid = 1'b0;
    end
    if (!dwl) begin
      bus.done = 1'b1;
      bus.fail = fail_b;
      tick();
    end
    bus.done = 1'b0;
    bus.fail = 1'b0;
  endtask

  // Called right after the edge that sampled done.
  task automatic check_outcome(input string name, input int rmode);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit seen = 0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_in_check: got %b want 1", name, bus.busy);
    end
    tick();
    if (exp_err) begin
      total++;
      if ({bus.err, bus.ok, bus.busy, bus.rd_valid} !== 4'b1000) begin
        bad++;
        $display("FAIL %s err_flags: got err=%b ok=%b busy=%b rd_valid=%b want 1 0 0 0",
                 name, bus.err, bus.ok, bus.busy, bus.rd_valid);
      end
      total++;
      if (bus.err_code !== exp_code) begin
        bad++;
        $display("FAIL %s err_code: got %b want %b", name, bus.err_code, exp_code);
      end
      total++;
      if (bus.path_len !== (AW+1)'(exp_len)) begin
        bad++;
        $display("FAIL %s path_len: got %0d want %0d", name, bus.path_len, exp_len);
      end
      repeat (4) begin
        tick();
        if (bus.rd_valid !== 1'b0) seen = 1;
      end
      total++;
      if (seen || bus.err !== 1'b1 || bus.err_code !== exp_code) begin
        bad++;
        $display("FAIL %s err_hold: got rd_valid_seen=%b err=%b code=%b want 0 1 %b",
                 name, seen, bus.err, bus.err_code, exp_code);
      end
    end else begin
      total++;
      if (bus.path_len !== (AW+1)'(exp_len)) begin
        bad++;
        $display("FAIL %s path_len: got %0d want %0d", name, bus.path_len, exp_len);
      end
      while (idx < exp_len && cyc < 2000) begin
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = ($urandom_range(0, 1) == 1);
        endcase
        bus.rd_ready = rdy;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_x !== CW'(exp_x[idx]) || bus.rd_y !== CW'(exp_y[idx])) begin
          bad++;
          $display("FAIL %s beat%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                   name, idx, bus.rd_valid, bus.rd_x, bus.rd_y, exp_x[idx], exp_y[idx]);
        end
        if (rdy) idx++;
        tick();
        cyc++;
      end
      bus.rd_ready = 1'b0;
      total++;
      if (idx != exp_len) begin
        bad++;
        $display("FAIL %s replay_timeout: got %0d beats want %0d", name, idx, exp_len);
      end
      total++;
      if ({bus.ok, bus.err, bus.busy, bus.rd_valid, bus.err_code} !== 6'b100000) begin
        bad++;
        $display("FAIL %s finish_ok: got ok=%b err=%b busy=%b rd_valid=%b code=%b want 1 0 0 0 00",
                 name, bus.ok, bus.err, bus.busy, bus.rd_valid, bus.err_code);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({bus.rd_valid, bus.busy, bus.ok, bus.err, bus.err_code} !== 6'b0 ||
        bus.path_len !== '0 || bus.rd_x !== '0 || bus.rd_y !== '0) begin
      bad++;
      $display("FAIL %s outputs: got v=%b busy=%b ok=%b err=%b code=%b len=%0d xy=(%0d,%0d) want all 0",
               name, bus.rd_valid, bus.busy, bus.ok, bus.err, bus.err_code, bus.path_len,
               bus.rd_x, bus.rd_y);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_ignore();
    bus.move_valid = 1'b1;
    bus.move       = 2'd1;
    bus.done       = 1'b1;
    repeat (3) tick();
    bus.move_valid = 1'b0;
    bus.done       = 1'b0;
    tick();
    check_all_zero("idle_ignore");
  endtask

  task automatic test_straight_path();
    mv_q.delete();
    repeat (15) mv_q.push_back(2'd1);
    repeat (15) mv_q.push_back(2'd3);
    fail_b = 0;
    build_model();
    drive_capture(0, 0);
    check_outcome("straight", 0);
  endtask

  task automatic test_toggle_ready();
    gen_goal_path(6);
    fail_b = 0;
    build_model();
    drive_capture(1, 1);
    check_outcome("toggle_ready", 1);
  endtask

  task automatic test_random_paths();
    for (int i = 0; i < 6; i++) begin
      gen_goal_path($urandom_range(0, 20));
      fail_b = 0;
      build_model();
      drive_capture(1'($urandom_range(0, 1)), 2);
      check_outcome($sformatf("random_path%0d", i), 2);
    end
  endtask

  task automatic test_out_of_bounds();
    gen_goal_path(0);
    mv_q.push_front(2'd2);
    fail_b = 0;
    build_model();
    drive_capture(0, 0);
    check_outcome("oob_left", 2);
    gen_goal_path(3);
    mv_q.push_back(2'd3);
    fail_b = 0;
    build_model();
    drive_capture(1, 1);
    check_outcome("oob_down_last", 2);
  endtask

  task automatic test_solver_fail();
    mv_q.delete();
    repeat (3) mv_q.push_back(2'($urandom_range(0, 3)));
    fail_b = 1;
    build_model();
    drive_capture(1, 0);
    check_outcome("solver_fail", 0);
  endtask

  task automatic test_random_errors();
    for (int i = 0; i < 8; i++) begin
      mv_q.delete();
      repeat ($urandom_range(0, 40)) mv_q.push_back(2'($urandom_range(0, 3)));
      fail_b = ($urandom_range(0, 3) == 0);
      build_model();
      drive_capture(1'($urandom_range(0, 1)), 1);
      check_outcome($sformatf("random_err%0d", i), 2);
    end
  endtask

  task automatic test_overflow();
    mv_q.delete();
    mv_q.push_back(2'd2);
    for (int i = 0; i < 259; i++) mv_q.push_back((i % 2 == 0) ? 2'd1 : 2'd2);
    fail_b = 0;
    build_model();
    drive_capture(0, 0);
    check_outcome("overflow", 0);
  endtask

  task automatic test_restart_in_replay();
    gen_goal_path(4);
    fail_b = 0;
    build_model();
    drive_capture(0, 0);
    tick();
    bus.rd_ready = 1'b1;
    repeat (3) tick();
    bus.rd_ready = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    total++;
    if ({bus.rd_valid, bus.busy, bus.ok, bus.err} !== 4'b0100 || bus.path_len !== '0) begin
      bad++;
      $display("FAIL restart_abort: got v=%b busy=%b ok=%b err=%b len=%0d want 0 1 0 0 0",
               bus.rd_valid, bus.busy, bus.ok, bus.err, bus.path_len);
    end
    gen_goal_path(2);
    build_model();
    drive_capture(1, 0);
    check_outcome("restart_new", 2);
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.move_valid = 1'b1;
    bus.move       = 2'd1;
    repeat (3) tick();
    bus.move_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.path_len !== (AW+1)'(3)) begin
      bad++;
      $display("FAIL pre_reset: got busy=%b len=%0d want 1 3", bus.busy, bus.path_len);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("after_reset");
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.move_valid = 1'b0;
    bus.move       = 2'd0;
    bus.done       = 1'b0;
    bus.fail       = 1'b0;
    bus.rd_ready   = 1'b0;
    test_reset();
    test_idle_ignore();
    test_straight_path();
    test_toggle_ready();
    test_random_paths();
    test_out_of_bounds();
    test_solver_fail();
    test_random_errors();
    test_overflow();
    test_restart_in_replay();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
